// File: rtl/phase_decimator.sv
// Decimates a loop phase-detector stream by block averaging (floor) and buffers
// the block results in a first-word-fall-through FIFO after a settling period.
module phase_decimator #(
   parameter int DECIM  = 64,
   parameter int DEPTH  = 16,
   parameter int SETTLE = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     tick_i,
   input  logic signed [15:0]       phase_i,
   input  logic                     clear_i,
   input  logic                     ready_i,
   output logic signed [15:0]       data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     settled_o,
   output logic                     overflow_o
);

   localparam int LD   = $clog2(DECIM);
   localparam int AW   = $clog2(DEPTH);
   localparam int ACCW = 16 + LD;

   typedef enum logic [0:0] {ST_SETTLE = 1'b0, ST_RUN = 1'b1} state_t;

   localparam state_t           INIT_ST     = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [LD-1:0]    SMP_LAST    = LD'(DECIM - 1);
   localparam logic [LD-1:0]    SMP_ONE     = LD'(1);
   localparam logic [AW-1:0]    PTR_ONE     = AW'(1);
   localparam logic [AW:0]      CNT_ONE     = (AW + 1)'(1);
   localparam logic [AW:0]      CNT_ZERO    = (AW + 1)'(0);
   localparam logic [AW:0]      CNT_FULL    = (AW + 1)'(DEPTH);

   state_t                  state_r, state_s;
   logic [7:0]              blk_cnt_r, blk_cnt_s;
   logic signed [ACCW-1:0]  acc_r;
   logic [LD-1:0]           smp_cnt_r;
   logic signed [15:0]      mem_r [DEPTH];
   logic [AW-1:0]           rd_ptr_r, wr_ptr_r, nrd_s;
   logic [AW:0]             count_r, count_s;
   logic signed [15:0]      data_r, head_s, result_s;
   logic                    valid_r, settled_r, overflow_r;
   logic signed [ACCW-1:0]  blk_sum_s, blk_shr_s;
   logic                    dump_s, push_s, pop_s, full_s, push_ok_s, drop_s;

   assign data_o     = data_r;
   assign valid_o    = valid_r;
   assign count_o    = count_r;
   assign settled_o  = settled_r;
   assign overflow_o = overflow_r;

   // Block arithmetic: the sum is exact at 16+log2(DECIM) bits, so the floor shift always fits 16 bits
   assign dump_s    = tick_i && (smp_cnt_r == SMP_LAST);
   assign blk_sum_s = acc_r + {{LD{phase_i[15]}}, phase_i};
   assign blk_shr_s = blk_sum_s >>> LD;
   assign result_s  = blk_shr_s[15:0];
   assign push_s    = dump_s && (state_r == ST_RUN) && !clear_i;
   assign pop_s     = valid_r && ready_i && !clear_i;
   assign full_s    = (count_r == CNT_FULL);
   assign push_ok_s = push_s && (!full_s || pop_s);
   assign drop_s    = push_s && full_s && !pop_s;

   // FSM next state: count discarded blocks until the loop is considered locked
   always_comb begin
      state_s   = state_r;
      blk_cnt_s = blk_cnt_r;
      if (clear_i) begin
         state_s   = INIT_ST;
         blk_cnt_s = 8'd0;
      end else begin
         case (state_r)
            ST_SETTLE: begin
               if (dump_s) begin
                  blk_cnt_s = blk_cnt_r + 8'd1;
                  if (blk_cnt_r == SETTLE_LAST) begin
                     state_s = ST_RUN;
                  end else begin
                     state_s = ST_SETTLE;
                  end
               end else begin
                  blk_cnt_s = blk_cnt_r;
               end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = INIT_ST;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r   <= INIT_ST;
         blk_cnt_r <= 8'd0;
      end else begin
         state_r   <= state_s;
         blk_cnt_r <= blk_cnt_s;
      end
   end

   // FIFO next occupancy and next head; a push into the new head slot bypasses storage
   always_comb begin
      case ({push_ok_s, pop_s})
         2'b10:   count_s = count_r + CNT_ONE;
         2'b01:   count_s = count_r - CNT_ONE;
         default: count_s = count_r;
      endcase
      if (pop_s) begin
         nrd_s = rd_ptr_r + PTR_ONE;
      end else begin
         nrd_s = rd_ptr_r;
      end
      if (count_s == CNT_ZERO) begin
         head_s = 16'sd0;
      end else if (push_ok_s && (wr_ptr_r == nrd_s)) begin
         head_s = result_s;
      end else begin
         head_s = mem_r[nrd_s];
      end
   end

   // FIFO storage, deliberately not reset
   always_ff @(posedge clk_i) begin
      if (rst_i && push_ok_s) begin
         mem_r[wr_ptr_r] <= result_s;
      end
   end

   // Accumulator, sample counter, FIFO pointers and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_i || clear_i) begin
         acc_r      <= {ACCW{1'b0}};
         smp_cnt_r  <= {LD{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= CNT_ZERO;
         valid_r    <= 1'b0;
         data_r     <= 16'sd0;
         overflow_r <= 1'b0;
         settled_r  <= (INIT_ST == ST_RUN);
      end else begin
         if (dump_s) begin
            acc_r     <= {ACCW{1'b0}};
            smp_cnt_r <= {LD{1'b0}};
         end else if (tick_i) begin
            acc_r     <= blk_sum_s;
            smp_cnt_r <= smp_cnt_r + SMP_ONE;
         end else begin
            acc_r     <= acc_r;
            smp_cnt_r <= smp_cnt_r;
         end
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r   <= nrd_s;
         count_r    <= count_s;
         valid_r    <= (count_s != CNT_ZERO);
         data_r     <= head_s;
         overflow_r <= overflow_r | drop_s;
         settled_r  <= (state_s == ST_RUN);
      end
   end

endmodule

// File: tb/tb_phase_decimator.sv
// Directed plus randomized bench for phase_decimator, checked every cycle
// against a block-list / queue reference model.
module tb_phase_decimator;

   localparam int DECIM  = 4;
   localparam int DEPTH  = 4;
   localparam int SETTLE = 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               tick = 1'b0;
   logic signed [15:0] phase = 16'sd0;
   logic               clear = 1'b0;
   logic               ready = 1'b0;
   logic signed [15:0] data;
   logic               valid;
   logic [2:0]         count;
   logic               settled;
   logic               overflow;

   int tests = 0;
   int fails = 0;

   int blk_q[$];
   int fifo_q[$];
   int discarded = 0;
   bit settled_m = 1'b0;
   bit ovf_m = 1'b0;

   phase_decimator #(.DECIM(DECIM), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .phase_i(phase), .clear_i(clear),
      .ready_i(ready), .data_o(data), .valid_o(valid), .count_o(count),
      .settled_o(settled), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   function automatic int floor_div(input int s, input int d);
      int q;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   task automatic model_init();
      blk_q.delete();
      fifo_q.delete();
      discarded = 0;
      settled_m = (SETTLE == 0);
      ovf_m = 1'b0;
   endtask

   // Reference behaviour at one rising edge, from the inputs present before it
   task automatic model_edge(input logic t, input int p, input logic c, input logic r, input logic rs);
      bit pop, push;
      int sum, v;
      if (!rs || c) begin
         model_init();
      end else begin
         pop = (fifo_q.size() != 0) && r;
         push = 1'b0;
         v = 0;
         if (t) begin
            blk_q.push_back(p);
            if (blk_q.size() == DECIM) begin
               sum = 0;
               foreach (blk_q[k]) sum += blk_q[k];
               v = floor_div(sum, DECIM);
               blk_q.delete();
               if (settled_m) begin
                  push = 1'b1;
               end else begin
                  discarded++;
                  if (discarded == SETTLE) settled_m = 1'b1;
               end
            end
         end
         if (pop) void'(fifo_q.pop_front());
         if (push) begin
            if (fifo_q.size() < DEPTH) fifo_q.push_back(v);
            else ovf_m = 1'b1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic step(input logic t, input logic signed [15:0] p, input logic c, input logic r, input logic rs);
      logic [15:0] exp_data;
      tick = t; phase = p; clear = c; ready = r; rst = rs;
      @(posedge clk);
      model_edge(t, int'(p), c, r, rs);
      #1;
      exp_data = (fifo_q.size() != 0) ? 16'(fifo_q[0]) : 16'd0;
      check("count", 16'(count), 16'(fifo_q.size()));
      check("valid", 16'(valid), 16'(fifo_q.size() != 0));
      check("data", data, exp_data);
      check("settled", 16'(settled), 16'(settled_m));
      check("overflow", 16'(overflow), 16'(ovf_m));
   endtask

   task automatic block(input int v, input logic r);
      for (int k = 0; k < DECIM; k++) step(1'b1, 16'(v), 1'b0, r, 1'b1);
   endtask

   task automatic idle(input int n, input logic r);
      for (int k = 0; k < n; k++) step(1'b0, 16'sd0, 1'b0, r, 1'b1);
   endtask

   initial begin
      model_init();
      // reset held two cycles with ticks toggling
      step(1'b1, 16'sd1000, 1'b0, 1'b1, 1'b0);
      step(1'b0, 16'sd1000, 1'b0, 1'b1, 1'b0);
      // constant 100: first block settles, second block stored and popped
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 16'sd100, 1'b0, 1'b1, 1'b1);
         step(1'b0, 16'sd100, 1'b0, 1'b1, 1'b1);
      end
      idle(2, 1'b1);
      // floor and extreme values
      step(1'b1, -16'sd3, 1'b0, 1'b1, 1'b1);
      step(1'b1, -16'sd3, 1'b0, 1'b1, 1'b1);
      step(1'b1, -16'sd3, 1'b0, 1'b1, 1'b1);
      step(1'b1, -16'sd2, 1'b0, 1'b1, 1'b1);
      block(32767, 1'b0);
      block(-32768, 1'b0);
      idle(3, 1'b1);
      // overflow: six blocks into four entries, then drain
      for (int v = 1; v <= 6; v++) block(v, 1'b0);
      idle(2, 1'b0);
      idle(6, 1'b1);
      // clear two ticks into a RUN block with two entries stored
      block(7, 1'b0);
      block(8, 1'b0);
      step(1'b1, 16'sd9, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'sd9, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'sd9, 1'b1, 1'b1, 1'b1);
      block(20, 1'b0);
      block(21, 1'b0);
      // full FIFO with pop in the exact push cycle, across pointer wrap
      for (int v = 22; v <= 24; v++) block(v, 1'b0);
      step(1'b1, 16'sd25, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'sd25, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'sd25, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'sd25, 1'b0, 1'b1, 1'b1);
      idle(2, 1'b0);
      idle(6, 1'b1);
      // randomized traffic with occasional clear and reset
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 79) == 0),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) != 0));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
